rvh_ptw_mem_responder: RTL and testbench
========================================

# rvh_ptw_mem_responder

Responder end of the MMU page-table-walk port. It accepts one PTE fetch request at a time from the MMU walker (`ptw_walk_req_*`) and issues an 8-byte aligned read to the memory/L1D port. It returns the 64-bit PTE on `ptw_walk_resp_*` with full valid/ready backpressure. It sits between the monolithic MMU and the data-side memory interface. An optional one-entry last-PTE cache short-circuits repeated fetches of the same PTE address.

## Interface
- `PTW_ID_WIDTH`, default 1, width of the walk request ID; the ID is forwarded to the memory request.
- `PADDR_WIDTH`, default 56, physical address width.
- `PTE_WIDTH`, default 64, PTE/data width. Fixed at 64; any other value is unsupported.
- `clk` in 1: the single clock.
- `rstn` in 1: reset; asynchronous, active-low.
- `ptw_walk_req_vld_i` in 1: walk request valid.
- `ptw_walk_req_id_i` in PTW_ID_WIDTH: walk request ID.
- `ptw_walk_req_addr_i` in PADDR_WIDTH: PTE physical address.
- `ptw_walk_req_rdy_o` out 1: responder can accept a request.
- `ptw_walk_resp_vld_o` out 1: PTE response valid.
- `ptw_walk_resp_pte_i`-side output `ptw_walk_resp_pte_o` out 64: PTE data.
- `ptw_walk_resp_rdy_i` in 1: walker accepts the response.
- `mem_req_vld_o` out 1: memory read request valid.
- `mem_req_id_o` out PTW_ID_WIDTH: captured walk ID.
- `mem_req_addr_o` out PADDR_WIDTH: captured address with bits [2:0] forced to 0.
- `mem_req_rdy_i` in 1: memory accepts the request.
- `mem_resp_vld_i` in 1: memory read data valid.
- `mem_resp_data_i` in 64: read data.
- `mem_resp_err_i` in 1: bus/access error on this response.
- `mem_resp_rdy_o` out 1: responder accepts memory data.
- `ptw_flush_i` in 1: invalidate the cached PTE. Connected to the TLB flush grant.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Only one transaction is outstanding.
- IDLE:
  - `ptw_walk_req_rdy_o` = 1.
  - On `req_vld`, capture the ID, the address with [2:0] zeroed, and move to REQ.
  - Cache hit, macro only: load the cached PTE and move to RESP instead.
- REQ:
  - `mem_req_vld_o` = 1, with the captured ID and address held stable.
  - On `mem_req_rdy_i`, move to WAIT.
- WAIT:
  - `mem_resp_rdy_o` = 1.
  - On `mem_resp_vld_i`, capture the PTE and move to RESP.
  - The captured PTE is `mem_resp_data_i`, or 64'h0 if `mem_resp_err_i` = 1. V=0 makes the walker raise a page fault.
- RESP:
  - `ptw_walk_resp_vld_o` = 1, with the PTE held stable until `ptw_walk_resp_rdy_i`.
  - On handshake, move to IDLE.
- `mem_resp_vld_i` outside WAIT is a protocol violation; it is ignored and `mem_resp_rdy_o` = 0.
- Reset value of every output is 0: all valid/ready outputs, `mem_req_id_o`, `mem_req_addr_o`, and the PTE output.
- Asserting `rstn` mid-transaction returns the FSM to IDLE and drops captured data. The memory side shares `rstn` and drops its in-flight response.

## Timing
- No combinational path from any input to any output; all outputs come from registers or the state decode.
- Request accepted at cycle 0 → `mem_req_vld_o` at cycle 1.
  - `mem_req_rdy_i` = 1 at cycle 1 → WAIT at cycle 2.
  - `mem_resp_vld_i` at cycle 2 → `ptw_walk_resp_vld_o` at cycle 3.
  - Miss latency is therefore 3 cycles plus memory and backpressure stalls.
- Cache hit (macro only): request at cycle 0 → `ptw_walk_resp_vld_o` at cycle 1.
- After the response handshake at cycle n, `ptw_walk_req_rdy_o` = 1 at cycle n+1. There is no same-cycle re-accept.

## Configuration
- Macro `RVH_PTW_LAST_PTE_CACHE_EN`.
- Defined:
  - One entry holds {valid, addr[PADDR_WIDTH-1:3], pte}. It is filled on every non-error memory response.
  - Hit in IDLE requires valid, a tag match, and `ptw_flush_i` = 0 in the same cycle.
  - `ptw_flush_i` clears valid in any state.
  - A flush seen in REQ or WAIT sets `flush_pend`. The next fill is then suppressed; the response is still returned. `flush_pend` clears on entry to IDLE.
  - An error response never fills and does not change valid.
- Undefined: no cache storage; `ptw_flush_i` is ignored; every request goes through REQ/WAIT.

## Test plan
- **Reset:** all outputs 0 during reset; after release, `ptw_walk_req_rdy_o` = 1 and `mem_req_vld_o` = 0.
- **Basic miss:** req addr 0x80001_0ABC, id 1, memory always ready.
  - Expect `mem_req_addr_o` = 0x80001_0AB8 and id 1 at cycle 1.
  - Memory data 0x2000_0401 at cycle 2 → `ptw_walk_resp_pte_o` = 0x2000_0401 at cycle 3.
- **Backpressure:**
  - `mem_req_rdy_i` low for 4 cycles → address held stable.
  - `ptw_walk_resp_rdy_i` low for 3 cycles → PTE held stable.
  - `ptw_walk_req_rdy_o` stays 0 until the cycle after the handshake.
- **Error:** `mem_resp_err_i` = 1 with data 0xFFFF → PTE response 0. With the macro, a repeat of the same address misses.
- **Cache, macro only:**
  - Repeat of address 0x1000 after a fill → response at cycle 1 with no `mem_req_vld_o`.
  - Flush between the two requests → full miss.
  - Flush during WAIT → that fill suppressed; the next request to the same address misses.
- **Reset mid-WAIT:** assert `rstn` low in WAIT → FSM in IDLE and no response; a following request completes normally.

Source files
------------

// File: rtl/rvh_ptw_mem_responder.sv
// -----------------------------------------------------------------------------
// rvh_ptw_mem_responder
//
// Responder end of the MMU page-table-walk port. Accepts one PTE fetch at a
// time from the walker, issues an 8-byte aligned read to the memory/L1D port
// and returns the 64-bit PTE with full valid/ready backpressure. A bus error
// returns an all-zero PTE (V=0) so the walker raises a page fault.
//
// Optional feature (define RVH_PTW_LAST_PTE_CACHE_EN): a one-entry last-PTE
// cache that answers a repeated fetch of the same PTE address in one cycle.
// Without the macro ptw_flush_i is ignored and every request goes to memory.
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   ptw_walk_req_{vld,id,addr}_i  walk request in;  ptw_walk_req_rdy_o out
//   ptw_walk_resp_{vld,pte}_o     PTE response out; ptw_walk_resp_rdy_i in
//   mem_req_{vld,id,addr}_o       memory read out;  mem_req_rdy_i in
//   mem_resp_{vld,data,err}_i     memory data in;   mem_resp_rdy_o out
//   ptw_flush_i                   invalidate the cached PTE (TLB flush grant)
//
// Every output is a flop, so there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module rvh_ptw_mem_responder #(
    parameter int PTW_ID_WIDTH = 1,
    parameter int PADDR_WIDTH  = 56,
    parameter int PTE_WIDTH    = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    ptw_walk_req_vld_i,
    input  logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i,
    input  logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i,
    output logic                    ptw_walk_req_rdy_o,
    output logic                    ptw_walk_resp_vld_o,
    output logic [PTE_WIDTH-1:0]    ptw_walk_resp_pte_o,
    input  logic                    ptw_walk_resp_rdy_i,
    output logic                    mem_req_vld_o,
    output logic [PTW_ID_WIDTH-1:0] mem_req_id_o,
    output logic [PADDR_WIDTH-1:0]  mem_req_addr_o,
    input  logic                    mem_req_rdy_i,
    input  logic                    mem_resp_vld_i,
    input  logic [PTE_WIDTH-1:0]    mem_resp_data_i,
    input  logic                    mem_resp_err_i,
    output logic                    mem_resp_rdy_o,
    input  logic                    ptw_flush_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int TAG_WIDTH = PADDR_WIDTH - 3;

    state_e                  state_q, state_d;
    logic [PTW_ID_WIDTH-1:0] id_q, id_d;
    logic [PADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [PTE_WIDTH-1:0]    pte_q, pte_d;
    logic                    req_rdy_q, req_rdy_d;
    logic                    mem_req_vld_q, mem_req_vld_d;
    logic                    mem_resp_rdy_q, mem_resp_rdy_d;
    logic                    resp_vld_q, resp_vld_d;

    logic                    cache_hit;
    logic [PTE_WIDTH-1:0]    cache_pte;

    // Address bits [2:0] never reach memory: the read is always 8-byte aligned.
    logic [2:0] unused_addr_lsb;
    assign unused_addr_lsb = ptw_walk_req_addr_i[2:0];

`ifdef RVH_PTW_LAST_PTE_CACHE_EN
    logic                 cache_vld_q, cache_vld_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [TAG_WIDTH-1:0] cache_tag_q;
    logic [PTE_WIDTH-1:0] cache_pte_q;
    logic                 cache_fill;

    assign cache_hit = cache_vld_q && !ptw_flush_i
                    && (cache_tag_q == ptw_walk_req_addr_i[PADDR_WIDTH-1:3]);
    assign cache_pte = cache_pte_q;

    // A flush seen while the fetch was in flight (or in the fill cycle itself)
    // means the returning PTE may be stale, so it must not be cached.
    assign cache_fill = (state_q == ST_WAIT) && mem_resp_vld_i && !mem_resp_err_i
                     && !flush_pend_q && !ptw_flush_i;

    always_comb begin
        cache_vld_d  = cache_vld_q;
        flush_pend_d = flush_pend_q;
        if (ptw_flush_i) begin
            cache_vld_d = 1'b0;
        end else if (cache_fill) begin
            cache_vld_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
            flush_pend_d = 1'b0;
        end else if (ptw_flush_i && (state_q == ST_REQ || state_q == ST_WAIT)) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cache_vld_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // NOTE: tag/data storage has no reset; cache_vld_q alone guards its use.
    always_ff @(posedge clk) begin
        if (cache_fill) begin
            cache_tag_q <= addr_q[PADDR_WIDTH-1:3];
            cache_pte_q <= mem_resp_data_i;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_pte = '0;

    logic unused_flush;
    assign unused_flush = ptw_flush_i;
`endif

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        pte_d   = pte_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ptw_walk_req_vld_i) begin
                    id_d   = ptw_walk_req_id_i;
                    addr_d = {ptw_walk_req_addr_i[PADDR_WIDTH-1:3], 3'b000};
                    if (cache_hit) begin
                        pte_d   = cache_pte;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_rdy_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_resp_vld_i) begin
                    // Zero PTE has V=0, which the walker turns into a page fault.
                    pte_d   = mem_resp_err_i ? '0 : mem_resp_data_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (ptw_walk_resp_rdy_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered decodes of the next state, so they
        // track state_q exactly yet read 0 while reset is asserted.
        req_rdy_d      = (state_d == ST_IDLE);
        mem_req_vld_d  = (state_d == ST_REQ);
        mem_resp_rdy_d = (state_d == ST_WAIT);
        resp_vld_d     = (state_d == ST_RESP);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            id_q           <= '0;
            addr_q         <= '0;
            pte_q          <= '0;
            req_rdy_q      <= 1'b0;
            mem_req_vld_q  <= 1'b0;
            mem_resp_rdy_q <= 1'b0;
            resp_vld_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            addr_q         <= addr_d;
            pte_q          <= pte_d;
            req_rdy_q      <= req_rdy_d;
            mem_req_vld_q  <= mem_req_vld_d;
            mem_resp_rdy_q <= mem_resp_rdy_d;
            resp_vld_q     <= resp_vld_d;
        end
    end

    assign ptw_walk_req_rdy_o  = req_rdy_q;
    assign ptw_walk_resp_vld_o = resp_vld_q;
    assign ptw_walk_resp_pte_o = pte_q;
    assign mem_req_vld_o       = mem_req_vld_q;
    assign mem_req_id_o        = id_q;
    assign mem_req_addr_o      = addr_q;
    assign mem_resp_rdy_o      = mem_resp_rdy_q;

endmodule

// File: tb/tb_rvh_ptw_mem_responder.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for rvh_ptw_mem_responder. Inputs change 1 ns
// after the rising edge and outputs are sampled there too. Cache-specific
// expectations switch on RVH_PTW_LAST_PTE_CACHE_EN.
// -----------------------------------------------------------------------------
module tb_rvh_ptw_mem_responder;

    localparam int IDW = 1;
    localparam int AW  = 56;
    localparam int DW  = 64;

    logic           clk = 1'b0;
    logic           rstn;
    logic           ptw_walk_req_vld_i;
    logic [IDW-1:0] ptw_walk_req_id_i;
    logic [AW-1:0]  ptw_walk_req_addr_i;
    logic           ptw_walk_req_rdy_o;
    logic           ptw_walk_resp_vld_o;
    logic [DW-1:0]  ptw_walk_resp_pte_o;
    logic           ptw_walk_resp_rdy_i;
    logic           mem_req_vld_o;
    logic [IDW-1:0] mem_req_id_o;
    logic [AW-1:0]  mem_req_addr_o;
    logic           mem_req_rdy_i;
    logic           mem_resp_vld_i;
    logic [DW-1:0]  mem_resp_data_i;
    logic           mem_resp_err_i;
    logic           mem_resp_rdy_o;
    logic           ptw_flush_i;

    int n_checks = 0;
    int n_fail   = 0;

    rvh_ptw_mem_responder #(
        .PTW_ID_WIDTH(IDW),
        .PADDR_WIDTH (AW),
        .PTE_WIDTH   (DW)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .ptw_walk_req_vld_i (ptw_walk_req_vld_i),
        .ptw_walk_req_id_i  (ptw_walk_req_id_i),
        .ptw_walk_req_addr_i(ptw_walk_req_addr_i),
        .ptw_walk_req_rdy_o (ptw_walk_req_rdy_o),
        .ptw_walk_resp_vld_o(ptw_walk_resp_vld_o),
        .ptw_walk_resp_pte_o(ptw_walk_resp_pte_o),
        .ptw_walk_resp_rdy_i(ptw_walk_resp_rdy_i),
        .mem_req_vld_o      (mem_req_vld_o),
        .mem_req_id_o       (mem_req_id_o),
        .mem_req_addr_o     (mem_req_addr_o),
        .mem_req_rdy_i      (mem_req_rdy_i),
        .mem_resp_vld_i     (mem_resp_vld_i),
        .mem_resp_data_i    (mem_resp_data_i),
        .mem_resp_err_i     (mem_resp_err_i),
        .mem_resp_rdy_o     (mem_resp_rdy_o),
        .ptw_flush_i        (ptw_flush_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until it is taken at a clock edge.
    task automatic accept(input logic [IDW-1:0] id, input logic [AW-1:0] addr);
        logic taken;
        taken = 1'b0;
        ptw_walk_req_vld_i  = 1'b1;
        ptw_walk_req_id_i   = id;
        ptw_walk_req_addr_i = addr;
        for (int i = 0; i < 20 && !taken; i++) begin
            taken = ptw_walk_req_rdy_o;
            tick();
        end
        ptw_walk_req_vld_i = 1'b0;
        n_checks++;
        if (!taken) begin
            n_fail++;
            $display("FAIL accept_timeout: request %h never accepted", addr);
        end
    endtask

    // Act as memory: take the pending read and return one beat.
    task automatic mem_serve(input logic [DW-1:0] data, input logic err);
        logic seen;
        seen = 1'b0;
        mem_req_rdy_i = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = mem_req_vld_o;
            tick();
        end
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = data;
        mem_resp_err_i  = err;
        tick();
        mem_resp_vld_i  = 1'b0;
        mem_resp_err_i  = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mem_req_timeout: no memory request seen");
        end
    endtask

    // Wait for the walk response, take it, and return the PTE observed.
    task automatic finish_resp(output logic [DW-1:0] pte);
        logic seen;
        seen = 1'b0;
        pte  = '0;
        ptw_walk_resp_rdy_i = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = ptw_walk_resp_vld_o;
            if (seen) pte = ptw_walk_resp_pte_o;
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL resp_timeout: no walk response seen");
        end
    endtask

    task automatic test_reset();
        rstn                = 1'b0;
        ptw_walk_req_vld_i  = 1'b0;
        ptw_walk_req_id_i   = '0;
        ptw_walk_req_addr_i = '0;
        ptw_walk_resp_rdy_i = 1'b1;
        mem_req_rdy_i       = 1'b1;
        mem_resp_vld_i      = 1'b0;
        mem_resp_data_i     = '0;
        mem_resp_err_i      = 1'b0;
        ptw_flush_i         = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({ptw_walk_req_rdy_o, ptw_walk_resp_vld_o, mem_req_vld_o, mem_resp_rdy_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {ptw_walk_req_rdy_o, ptw_walk_resp_vld_o, mem_req_vld_o, mem_resp_rdy_o});
        end
        n_checks++;
        if ({ptw_walk_resp_pte_o, mem_req_addr_o, mem_req_id_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: pte %h addr %h id %h expected all 0",
                     ptw_walk_resp_pte_o, mem_req_addr_o, mem_req_id_o);
        end
        rstn = 1'b1;
        tick();
        n_checks++;
        if (ptw_walk_req_rdy_o !== 1'b1 || mem_req_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: req_rdy %b mem_req_vld %b expected 1 0",
                     ptw_walk_req_rdy_o, mem_req_vld_o);
        end
    endtask

    task automatic test_basic_miss();
        accept(1'b1, 56'h8_0001_0ABC);
        // cycle 1
        n_checks++;
        if (mem_req_vld_o !== 1'b1 || mem_req_addr_o !== 56'h8_0001_0AB8 || mem_req_id_o !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_mem_req: vld %b addr %h id %h expected 1 800010ab8 1",
                     mem_req_vld_o, mem_req_addr_o, mem_req_id_o);
        end
        n_checks++;
        if (ptw_walk_req_rdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_req_rdy_busy: got %b expected 0", ptw_walk_req_rdy_o);
        end
        tick();
        // cycle 2
        n_checks++;
        if (mem_resp_rdy_o !== 1'b1 || mem_req_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_wait: mem_resp_rdy %b mem_req_vld %b expected 1 0",
                     mem_resp_rdy_o, mem_req_vld_o);
        end
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = 64'h2000_0401;
        tick();
        mem_resp_vld_i  = 1'b0;
        // cycle 3
        n_checks++;
        if (ptw_walk_resp_vld_o !== 1'b1 || ptw_walk_resp_pte_o !== 64'h2000_0401) begin
            n_fail++;
            $display("FAIL miss_resp: vld %b pte %h expected 1 20000401",
                     ptw_walk_resp_vld_o, ptw_walk_resp_pte_o);
        end
        n_checks++;
        if (mem_resp_rdy_o !== 1'b0 || ptw_walk_req_rdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_resp_rdys: mem_resp_rdy %b req_rdy %b expected 0 0",
                     mem_resp_rdy_o, ptw_walk_req_rdy_o);
        end
        tick();
        n_checks++;
        if (ptw_walk_req_rdy_o !== 1'b1 || ptw_walk_resp_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_back_idle: req_rdy %b resp_vld %b expected 1 0",
                     ptw_walk_req_rdy_o, ptw_walk_resp_vld_o);
        end
    endtask

    task automatic test_backpressure();
        mem_req_rdy_i = 1'b0;
        accept(1'b0, 56'h12_3456_789F);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem_req_vld_o !== 1'b1 || mem_req_addr_o !== 56'h12_3456_7898 || mem_req_id_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_mem_hold[%0d]: vld %b addr %h id %h expected 1 12345678 98 0",
                         i, mem_req_vld_o, mem_req_addr_o, mem_req_id_o);
            end
            tick();
        end
        mem_req_rdy_i = 1'b1;
        tick();
        ptw_walk_resp_rdy_i = 1'b0;
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = 64'hDEAD_BEEF_0000_00C1;
        tick();
        mem_resp_vld_i  = 1'b0;
        mem_resp_data_i = 64'h5555_5555_5555_5555;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ptw_walk_resp_vld_o !== 1'b1 || ptw_walk_resp_pte_o !== 64'hDEAD_BEEF_0000_00C1
                || ptw_walk_req_rdy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_resp_hold[%0d]: vld %b pte %h req_rdy %b expected 1 deadbeef000000c1 0",
                         i, ptw_walk_resp_vld_o, ptw_walk_resp_pte_o, ptw_walk_req_rdy_o);
            end
            tick();
        end
        ptw_walk_resp_rdy_i = 1'b1;
        n_checks++;
        if (ptw_walk_req_rdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hs_cycle_rdy: got %b expected 0", ptw_walk_req_rdy_o);
        end
        tick();
        n_checks++;
        if (ptw_walk_req_rdy_o !== 1'b1 || ptw_walk_resp_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_after_hs: req_rdy %b resp_vld %b expected 1 0",
                     ptw_walk_req_rdy_o, ptw_walk_resp_vld_o);
        end
    endtask

    task automatic test_stray_mem_resp();
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = 64'hBAD0_BAD0;
        tick();
        tick();
        n_checks++;
        if (mem_resp_rdy_o !== 1'b0 || ptw_walk_resp_vld_o !== 1'b0 || ptw_walk_req_rdy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_resp: mem_resp_rdy %b resp_vld %b req_rdy %b expected 0 0 1",
                     mem_resp_rdy_o, ptw_walk_resp_vld_o, ptw_walk_req_rdy_o);
        end
        mem_resp_vld_i = 1'b0;
    endtask

    task automatic test_error();
        logic [DW-1:0] pte;
        accept(1'b0, 56'h2000);
        mem_serve(64'hFFFF, 1'b1);
        finish_resp(pte);
        n_checks++;
        if (pte !== 64'h0) begin
            n_fail++;
            $display("FAIL err_pte: got %h expected 0", pte);
        end
        accept(1'b0, 56'h2000);
        n_checks++;
        if (mem_req_vld_o !== 1'b1 || ptw_walk_resp_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_repeat_miss: mem_req_vld %b resp_vld %b expected 1 0",
                     mem_req_vld_o, ptw_walk_resp_vld_o);
        end
        mem_serve(64'h2000_00CF, 1'b0);
        finish_resp(pte);
        n_checks++;
        if (pte !== 64'h2000_00CF) begin
            n_fail++;
            $display("FAIL err_repeat_pte: got %h expected 200000cf", pte);
        end
    endtask

    task automatic test_repeat_and_flush();
        logic [DW-1:0] pte;
        accept(1'b1, 56'h1000);
        mem_serve(64'h0000_0000_1234_5001, 1'b0);
        finish_resp(pte);
        accept(1'b1, 56'h1004);
`ifdef RVH_PTW_LAST_PTE_CACHE_EN
        n_checks++;
        if (ptw_walk_resp_vld_o !== 1'b1 || mem_req_vld_o !== 1'b0
            || ptw_walk_resp_pte_o !== 64'h1234_5001) begin
            n_fail++;
            $display("FAIL hit_resp: resp_vld %b mem_req_vld %b pte %h expected 1 0 12345001",
                     ptw_walk_resp_vld_o, mem_req_vld_o, ptw_walk_resp_pte_o);
        end
        tick();
`else
        n_checks++;
        if (mem_req_vld_o !== 1'b1 || ptw_walk_resp_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_miss: mem_req_vld %b resp_vld %b expected 1 0",
                     mem_req_vld_o, ptw_walk_resp_vld_o);
        end
        mem_serve(64'h0000_0000_1234_5001, 1'b0);
        finish_resp(pte);
`endif
        // Flush in IDLE between two fetches of the same address.
        ptw_flush_i = 1'b1;
        tick();
        ptw_flush_i = 1'b0;
        accept(1'b1, 56'h1000);
        n_checks++;
        if (mem_req_vld_o !== 1'b1 || ptw_walk_resp_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_miss: mem_req_vld %b resp_vld %b expected 1 0",
                     mem_req_vld_o, ptw_walk_resp_vld_o);
        end
        mem_serve(64'h0000_0000_1234_5001, 1'b0);
        finish_resp(pte);

        // Flush while the fetch is in WAIT: response still returned, no fill.
        accept(1'b0, 56'h3000);
        tick();
        ptw_flush_i = 1'b1;
        tick();
        ptw_flush_i     = 1'b0;
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = 64'h0000_0000_0003_3001;
        tick();
        mem_resp_vld_i  = 1'b0;
        n_checks++;
        if (ptw_walk_resp_vld_o !== 1'b1 || ptw_walk_resp_pte_o !== 64'h3_3001) begin
            n_fail++;
            $display("FAIL flush_wait_resp: vld %b pte %h expected 1 33001",
                     ptw_walk_resp_vld_o, ptw_walk_resp_pte_o);
        end
        tick();
        accept(1'b0, 56'h3000);
        n_checks++;
        if (mem_req_vld_o !== 1'b1 || ptw_walk_resp_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wait_no_fill: mem_req_vld %b resp_vld %b expected 1 0",
                     mem_req_vld_o, ptw_walk_resp_vld_o);
        end
        mem_serve(64'h0000_0000_0003_3001, 1'b0);
        finish_resp(pte);
    endtask

    task automatic test_reset_mid_wait();
        logic [DW-1:0] pte;
        accept(1'b1, 56'h4000);
        tick();
        n_checks++;
        if (mem_resp_rdy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_in_wait: mem_resp_rdy %b expected 1", mem_resp_rdy_o);
        end
        rstn = 1'b0;
        mem_resp_vld_i  = 1'b1;
        mem_resp_data_i = 64'h4444_4001;
        #1;
        n_checks++;
        if ({ptw_walk_resp_vld_o, mem_resp_rdy_o, mem_req_vld_o, ptw_walk_req_rdy_o} !== 4'b0000
            || mem_req_addr_o !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: flags %b addr %h expected 0000 0",
                     {ptw_walk_resp_vld_o, mem_resp_rdy_o, mem_req_vld_o, ptw_walk_req_rdy_o},
                     mem_req_addr_o);
        end
        tick();
        mem_resp_vld_i = 1'b0;
        rstn = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ptw_walk_req_rdy_o !== 1'b1 || ptw_walk_resp_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: req_rdy %b resp_vld %b expected 1 0",
                     ptw_walk_req_rdy_o, ptw_walk_resp_vld_o);
        end
        accept(1'b0, 56'h5008);
        n_checks++;
        if (mem_req_vld_o !== 1'b1 || mem_req_addr_o !== 56'h5008) begin
            n_fail++;
            $display("FAIL rst_mid_next_req: vld %b addr %h expected 1 5008",
                     mem_req_vld_o, mem_req_addr_o);
        end
        mem_serve(64'h0000_0000_5555_5001, 1'b0);
        finish_resp(pte);
        n_checks++;
        if (pte !== 64'h5555_5001) begin
            n_fail++;
            $display("FAIL rst_mid_next_pte: got %h expected 55555001", pte);
        end
    endtask

    initial begin
        test_reset();
        test_basic_miss();
        test_backpressure();
        test_stray_mem_resp();
        test_error();
        test_repeat_and_flush();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
